crc_frame_serializer: RTL and testbench

//  Upstream feeder for the serial CRC engine. Accepts bytes over a valid/ready handshake into a small FIFO.

---
 rtl/crc_frame_serializer_pkg.sv | 15 +
 rtl/crc_frame_serializer_if.sv | 21 ++
 rtl/crc_frame_serializer_fifo.sv | 61 ++++++
 rtl/crc_frame_serializer.sv | 172 +++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_frame_serializer_pkg.sv
// Shared types for the CRC frame serializer.
// FSM encoding and default byte width.
package crc_pkg;

   localparam int CRC_WD = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT    = 3'd1,
      WAIT_VLD = 3'd2,
      DRAIN    = 3'd3,
      GAP      = 3'd4
   } state_t;

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Byte input handshake for the CRC frame serializer.
// The producer drives data/valid, the serializer answers with ready.
interface crc_frame_serializer_if #(
   parameter int DATA_WD = 8
);
   logic [DATA_WD-1:0] In_Data;
   logic               In_Valid;
   logic               In_Ready;

   modport master (
      output In_Data,
      output In_Valid,
      input  In_Ready
   );

   modport slave (
      input  In_Data,
      input  In_Valid,
      output In_Ready
   );
endinterface

// File: rtl/crc_frame_serializer_fifo.sv
// Byte buffer for the serializer; exposes the head and the entry behind it
// so the next byte of a frame is available at the pop edge.
module crc_byte_fifo
   import crc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CRC_WD
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [WIDTH-1:0]           next_head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head      = mem[rd_ptr];
   assign next_head = mem[inc(rd_ptr)];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/crc_frame_serializer.sv
// Feeds buffered frames LSB-first into the serial CRC engine and polices
// the engine's Valid window (timeout, window length, idle gap).
module crc_frame_serializer
   import crc_pkg::*;
#(
   parameter int DATA_WD     = CRC_WD,
   parameter int FRAME_BYTES = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int TIMEOUT     = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   crc_frame_serializer_if.slave bus,
   input  logic                 Valid,
   output logic                 DATA,
   output logic                 Active,
   output logic                 Busy,
   output logic                 Frame_Done,
   output logic                 Err_Tmo,
   output logic                 Err_Len
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(DATA_WD + 1);
   localparam int YW = $clog2(FRAME_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(DATA_WD + 2);
   localparam int GW = $clog2(GAP_CYCLES + 2);

   state_t state, state_nxt;

   logic [BW-1:0]      bit_cnt, bit_nxt;
   logic [YW-1:0]      byte_cnt, byte_nxt;
   logic [TW-1:0]      wait_cnt, wait_nxt;
   logic [LW-1:0]      len_cnt, len_nxt;
   logic [GW-1:0]      gap_cnt, gap_nxt;
   logic [DATA_WD-1:0] head, next_head, cur;
   logic [CW-1:0]      count;
   logic full, empty, push, pop;
   logic data_nxt, active_nxt, busy_nxt;
   logic done_nxt, tmo_nxt, elen_nxt;

   assign push         = bus.In_Valid & ~full;
   assign bus.In_Ready = ~full;

   crc_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WD)
   ) u_fifo (
      .clk       (CLK),
      .rst_n     (RST),
      .push      (push),
      .pop       (pop),
      .din       (bus.In_Data),
      .head      (head),
      .next_head (next_head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      state_nxt  = state;
      bit_nxt    = bit_cnt;
      byte_nxt   = byte_cnt;
      wait_nxt   = wait_cnt;
      len_nxt    = len_cnt;
      gap_nxt    = gap_cnt;
      cur        = head;
      active_nxt = 1'b0;
      done_nxt   = 1'b0;
      tmo_nxt    = 1'b0;
      elen_nxt   = 1'b0;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && count >= CW'(FRAME_BYTES)) begin
               state_nxt  = SHIFT;
               bit_nxt    = '0;
               byte_nxt   = '0;
               active_nxt = 1'b1;
            end
         end
         SHIFT: begin
            active_nxt = 1'b1;
            if (bit_cnt == BW'(DATA_WD - 1)) begin
               // next byte is read behind the head so the burst never gaps
               pop     = 1'b1;
               bit_nxt = '0;
               cur     = next_head;
               if (byte_cnt == YW'(FRAME_BYTES - 1)) begin
                  active_nxt = 1'b0;
                  wait_nxt   = '0;
                  state_nxt  = WAIT_VLD;
               end else begin
                  byte_nxt = byte_cnt + YW'(1);
               end
            end else begin
               bit_nxt = bit_cnt + BW'(1);
            end
         end
         WAIT_VLD: begin
            if (Valid) begin
               len_nxt   = LW'(1);
               state_nxt = DRAIN;
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
               tmo_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               wait_nxt = wait_cnt + TW'(1);
            end
         end
         DRAIN: begin
            if (Valid) begin
               if (len_cnt != LW'(DATA_WD + 1)) len_nxt = len_cnt + LW'(1);
            end else begin
               elen_nxt = (len_cnt != LW'(DATA_WD));
               gap_nxt  = '0;
               if (GAP_CYCLES == 0) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt + GW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      data_nxt = active_nxt & (|(cur & (DATA_WD'(1) << bit_nxt)));
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         wait_cnt   <= '0;
         len_cnt    <= '0;
         gap_cnt    <= '0;
         DATA       <= 1'b0;
         Active     <= 1'b0;
         Busy       <= 1'b0;
         Frame_Done <= 1'b0;
         Err_Tmo    <= 1'b0;
         Err_Len    <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_nxt;
         byte_cnt   <= byte_nxt;
         wait_cnt   <= wait_nxt;
         len_cnt    <= len_nxt;
         gap_cnt    <= gap_nxt;
         DATA       <= data_nxt;
         Active     <= active_nxt;
         Busy       <= busy_nxt;
         Frame_Done <= done_nxt;
         Err_Tmo    <= tmo_nxt;
         Err_Len    <= elen_nxt;
      end
   end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Bench for crc_frame_serializer: fixed vector table, a two-byte frame
// instance, and a timeline reference model driving randomized traffic.
module tb_crc_frame_serializer;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int GAPC  = 2;
   localparam int TMO   = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   crc_frame_serializer_if #(.DATA_WD(W)) if1 ();
   crc_frame_serializer_if #(.DATA_WD(W)) if2 ();

   logic valid1 = 1'b0, valid2 = 1'b0;
   logic data1, act1, busy1, done1, tmo1, len1;
   logic data2, act2, busy2, done2, tmo2, len2;

   crc_frame_serializer #(
      .DATA_WD(W), .FRAME_BYTES(1), .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(GAPC), .TIMEOUT(TMO)
   ) u1 (
      .CLK(clk), .RST(rst), .bus(if1.slave), .Valid(valid1),
      .DATA(data1), .Active(act1), .Busy(busy1),
      .Frame_Done(done1), .Err_Tmo(tmo1), .Err_Len(len1)
   );

   crc_frame_serializer #(
      .DATA_WD(W), .FRAME_BYTES(2), .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(GAPC), .TIMEOUT(TMO)
   ) u2 (
      .CLK(clk), .RST(rst), .bus(if2.slave), .Valid(valid2),
      .DATA(data2), .Active(act2), .Busy(busy2),
      .Frame_Done(done2), .Err_Tmo(tmo2), .Err_Len(len2)
   );

   int checks = 0;
   int fails  = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (!ok) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // {act,dat,bsy,done,rdy,err}
   typedef struct {
      bit         iv;
      logic [7:0] id;
      bit         vl;
      logic [5:0] exp;
   } vec_t;
   vec_t tab[23];

   // Reference model: absolute-cycle timeline of the frame in flight
   int         cyc, cnt, s, cyc0, c, lent, d, L;
   bit         have, tmo_c;
   logic [7:0] fr;
   logic [7:0] q[$];
   logic [7:0] push_q[$];
   bit         rnd_plan, rnd_push, plan_tmo;
   int         plan_d, plan_L;

   task automatic step(input bit rst_req);
      logic [6:0] got, exp;
      bit         act_e, pop_e, acc, iv;
      logic [7:0] id;
      act_e  = have && cyc >= s && cyc < cyc0;
      exp[6] = act_e;
      exp[5] = act_e ? fr[cyc - s] : 1'b0;
      exp[4] = have && cyc >= s && cyc < c;
      exp[3] = have && cyc == c && !tmo_c;
      exp[2] = have && cyc == c && tmo_c;
      exp[1] = have && !tmo_c && cyc == lent && L != W;
      exp[0] = (cnt < DEPTH);
      got = {act1, data1, busy1, done1, tmo1, len1, if1.In_Ready};
      chk(got === exp, $sformatf("model@%0d", cyc), 16'(got), 16'(exp));
      if (have && cyc == c) have = 0;
      valid1 = !rst_req && have && !tmo_c &&
               cyc >= cyc0 + d && cyc < cyc0 + d + L;
      iv = 0;
      id = '0;
      if (!rst_req) begin
         if (push_q.size() > 0) begin
            iv = 1;
            id = push_q[0];
         end else if (rnd_push && $urandom_range(0, 7) == 0) begin
            iv = 1;
            id = 8'($urandom);
         end
      end
      acc   = iv && cnt < DEPTH;
      pop_e = act_e && ((cyc - s) % W == W - 1);
      if (!rst_req && !have && cnt >= 1) begin
         have = 1;
         s    = cyc + 1;
         fr   = q.pop_front();
         cyc0 = s + W;
         if (rnd_plan) begin
            tmo_c = ($urandom_range(0, 4) == 0);
            d     = $urandom_range(0, TMO - 1);
            L     = $urandom_range(1, 11);
         end else begin
            tmo_c = plan_tmo;
            d     = plan_d;
            L     = plan_L;
         end
         lent = cyc0 + d + L + 1;
         c    = tmo_c ? cyc0 + TMO : lent + GAPC;
      end
      if (acc) begin
         q.push_back(id);
         if (push_q.size() > 0) void'(push_q.pop_front());
      end
      cnt = cnt + int'(acc) - int'(pop_e);
      if (rst_req) begin
         cnt  = 0;
         have = 0;
         q.delete();
         push_q.delete();
      end
      if1.In_Valid = iv;
      if1.In_Data  = id;
      rst          = !rst_req;
      @(negedge clk);
      rst = 1'b1;
      cyc++;
   endtask

   task automatic run_idle(input int budget, input string name);
      int n = 0;
      while ((have || push_q.size() > 0 || cnt > 0) && n < budget) begin
         step(0);
         n++;
      end
      chk(!(have || push_q.size() > 0 || cnt > 0), name,
          16'(n), 16'(budget));
   endtask

   logic [5:0]  got6;
   logic [15:0] bits;
   int first, nact, rises, done_at, errs, n;
   bit prev;

   initial begin
      if1.In_Valid = 0; if1.In_Data = '0;
      if2.In_Valid = 0; if2.In_Data = '0;
      tab[0]  = '{1'b1, 8'hA5, 1'b0, 6'b000010};
      tab[1]  = '{1'b0, 8'h00, 1'b0, 6'b000010};
      tab[2]  = '{1'b0, 8'h00, 1'b0, 6'b111010};
      tab[3]  = '{1'b0, 8'h00, 1'b0, 6'b101010};
      tab[4]  = '{1'b0, 8'h00, 1'b0, 6'b111010};
      tab[5]  = '{1'b0, 8'h00, 1'b0, 6'b101010};
      tab[6]  = '{1'b0, 8'h00, 1'b0, 6'b101010};
      tab[7]  = '{1'b0, 8'h00, 1'b0, 6'b111010};
      tab[8]  = '{1'b0, 8'h00, 1'b0, 6'b101010};
      tab[9]  = '{1'b0, 8'h00, 1'b0, 6'b111010};
      for (int j = 10; j < 18; j++)
         tab[j] = '{1'b0, 8'h00, 1'b1, 6'b001010};
      tab[18] = '{1'b0, 8'h00, 1'b0, 6'b001010};
      tab[19] = '{1'b0, 8'h00, 1'b0, 6'b001010};
      tab[20] = '{1'b0, 8'h00, 1'b0, 6'b001010};
      tab[21] = '{1'b0, 8'h00, 1'b0, 6'b000110};
      tab[22] = '{1'b0, 8'h00, 1'b0, 6'b000010};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // single A5 frame, exact per-cycle outputs
      for (int j = 0; j < 23; j++) begin
         got6 = {act1, data1, busy1, done1, if1.In_Ready, len1 | tmo1};
         chk(got6 === tab[j].exp, $sformatf("tab[%0d]", j),
             16'(got6), 16'(tab[j].exp));
         if1.In_Valid = tab[j].iv;
         if1.In_Data  = tab[j].id;
         valid1       = tab[j].vl;
         @(negedge clk);
      end

      // two-byte frame on the second instance
      bits = '0; first = -1; nact = 0; rises = 0;
      done_at = -1; errs = 0; prev = 0;
      for (int j = 0; j < 40; j++) begin
         if (act2) begin
            if (first < 0) first = j;
            if (j - first < 16) bits[j - first] = data2;
            nact++;
         end
         if (act2 && !prev) rises++;
         prev = act2;
         if (done2) done_at = j;
         if (len2 || tmo2) errs++;
         if2.In_Valid = (j < 2);
         if2.In_Data  = (j == 0) ? 8'h01 : 8'h80;
         valid2       = (j >= 19 && j < 27);
         @(negedge clk);
      end
      if2.In_Valid = 0;
      chk(first == 3, "fb2_start", 16'(first), 16'd3);
      chk(bits == 16'h8001, "fb2_bits", bits, 16'h8001);
      chk(nact == 16, "fb2_len", 16'(nact), 16'd16);
      chk(rises == 1, "fb2_burst", 16'(rises), 16'd1);
      chk(done_at == 30, "fb2_done", 16'(done_at), 16'd30);
      chk(errs == 0, "fb2_err", 16'(errs), 16'd0);

      cyc = 0; cnt = 0; have = 0; tmo_c = 0;
      s = 0; cyc0 = 0; c = 0; lent = 0; d = 0; L = 0; fr = '0;
      rnd_plan = 0; rnd_push = 0;
      plan_tmo = 0; plan_d = 0; plan_L = W;
      step(1);

      push_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_idle(600, "fill5");

      plan_tmo = 1;
      push_q.push_back(8'h5A);
      run_idle(200, "timeout");

      plan_tmo = 0; plan_L = 6;
      push_q.push_back(8'hC3);
      run_idle(200, "short_valid");

      plan_d = TMO - 1; plan_L = W;
      push_q.push_back(8'h96);
      run_idle(200, "late_valid");

      plan_d = 0;
      push_q.push_back(8'hFF);
      n = 0;
      while (!(have && cyc == s + 3) && n < 60) begin
         step(0);
         n++;
      end
      chk(have && cyc == s + 3, "reach_bit3", 16'(n), 16'd60);
      step(1);
      chk(act1 === 1'b0 && if1.In_Ready === 1'b1 && busy1 === 1'b0,
          "mid_reset", {13'd0, act1, if1.In_Ready, busy1}, 16'h2);
      push_q.push_back(8'h3C);
      run_idle(200, "after_reset");

      rnd_plan = 1; rnd_push = 1;
      repeat (3000) step(0);
      rnd_push = 0;
      run_idle(3000, "random_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
